// File: rtl/gpio_pad_ctrl_if.sv
// Register-file and pad-cell side signals of the GPIO pad controller.
// The core modport is what the controller sees; host is the driving side.
interface gpio_pad_ctrl_if #(
  parameter int NUM_PINS     = 8,
  parameter int IOCELL_CFG_W = 3,
  parameter int FILT_W       = 4
);
  logic [NUM_PINS-1:0]                  dir_i;
  logic [NUM_PINS-1:0]                  out_i;
  logic [NUM_PINS*(IOCELL_CFG_W-1)-1:0] pad_cfg_i;
  logic [FILT_W-1:0]                    filt_len_i;
  logic [NUM_PINS-1:0]                  irq_rise_en_i;
  logic [NUM_PINS-1:0]                  irq_fall_en_i;
  logic [NUM_PINS-1:0]                  irq_clr_i;
  logic [NUM_PINS-1:0]                  in_o;
  logic [NUM_PINS-1:0]                  irq_pend_o;
  logic                                 irq_o;
  logic [NUM_PINS*IOCELL_CFG_W-1:0]     io_cell_cfg_o;
  logic [NUM_PINS-1:0]                  from_core_o;
  logic [NUM_PINS-1:0]                  to_core_i;

  modport core (
    input  dir_i, out_i, pad_cfg_i, filt_len_i,
    input  irq_rise_en_i, irq_fall_en_i, irq_clr_i, to_core_i,
    output in_o, irq_pend_o, irq_o, io_cell_cfg_o, from_core_o
  );

  modport host (
    output dir_i, out_i, pad_cfg_i, filt_len_i,
    output irq_rise_en_i, irq_fall_en_i, irq_clr_i, to_core_i,
    input  in_o, irq_pend_o, irq_o, io_cell_cfg_o, from_core_o
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Core-side GPIO pad controller: registered pad drive/config, synchronized and
// glitch-filtered pad inputs, and per-pin edge interrupt flags.
module gpio_pad_ctrl #(
  parameter int NUM_PINS     = 8,
  parameter int IOCELL_CFG_W = 3,
  parameter int FILT_W       = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  gpio_pad_ctrl_if.core     bus
);

  localparam int XW = IOCELL_CFG_W - 1;

  logic [NUM_PINS-1:0]              from_core_q;
  logic [NUM_PINS*IOCELL_CFG_W-1:0] cfg_q;
  logic [NUM_PINS-1:0]              s1;
  logic [NUM_PINS-1:0]              s2;
  logic [NUM_PINS-1:0]              in_q;
  logic [NUM_PINS-1:0]              pend_q;
  logic [FILT_W-1:0]                cnt [NUM_PINS];

  logic [NUM_PINS-1:0]              accept;
  logic [NUM_PINS-1:0]              rise_set;
  logic [NUM_PINS-1:0]              fall_set;

  // A differing level is accepted once it has already been seen L times;
  // >= keeps a mid-count reduction of L from stalling the counter.
  always_comb begin
    accept = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      accept[p] = (s2[p] != in_q[p]) && (cnt[p] >= bus.filt_len_i);
    end
  end

  assign rise_set = accept &  s2 & bus.irq_rise_en_i;
  assign fall_set = accept & ~s2 & bus.irq_fall_en_i;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      from_core_q <= '0;
      s1          <= '0;
      s2          <= '0;
      in_q        <= '0;
      pend_q      <= '0;
      for (int p = 0; p < NUM_PINS; p++) begin
        cfg_q[p*IOCELL_CFG_W +: IOCELL_CFG_W] <= {{XW{1'b0}}, 1'b1};
        cnt[p]                                <= '0;
      end
    end else begin
      from_core_q <= bus.out_i;
      s1          <= bus.to_core_i;
      s2          <= s1;
      // set wins over a coincident clear
      pend_q      <= rise_set | fall_set | (pend_q & ~bus.irq_clr_i);
      for (int p = 0; p < NUM_PINS; p++) begin
        cfg_q[p*IOCELL_CFG_W]           <= ~bus.dir_i[p];
        cfg_q[p*IOCELL_CFG_W + 1 +: XW] <= bus.pad_cfg_i[p*XW +: XW];
        if (s2[p] == in_q[p]) begin
          cnt[p] <= '0;
        end else if (accept[p]) begin
          in_q[p] <= s2[p];
          cnt[p]  <= '0;
        end else begin
          cnt[p]  <= cnt[p] + 1'b1;
        end
      end
    end
  end

  assign bus.from_core_o   = from_core_q;
  assign bus.io_cell_cfg_o = cfg_q;
  assign bus.in_o          = in_q;
  assign bus.irq_pend_o    = pend_q;
  assign bus.irq_o         = |pend_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl; expectations are queued with the edge
// count after which they must hold and checked by an independent monitor.
module tb_gpio_pad_ctrl;

  localparam int NP = 8;
  localparam int CW = 3;
  localparam int FW = 4;

  localparam int SIG_IN   = 0;
  localparam int SIG_PEND = 1;
  localparam int SIG_IRQ  = 2;
  localparam int SIG_FROM = 3;
  localparam int SIG_CFG  = 4;
  localparam int SIG_CNT4 = 5;

  typedef struct {
    int          due;
    string       name;
    int          sig;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  logic clk_in;
  logic reset_in;
  int   edge_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  gpio_pad_ctrl_if #(.NUM_PINS(NP), .IOCELL_CFG_W(CW), .FILT_W(FW)) bus ();

  gpio_pad_ctrl #(.NUM_PINS(NP), .IOCELL_CFG_W(CW), .FILT_W(FW)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial edge_n = 0;
  always @(posedge clk_in) edge_n <= edge_n + 1;

  function automatic void push(int due, string name, int sig,
                               logic [31:0] mask, logic [31:0] exp);
    exp_t e;
    int   i;
    e.due  = due;
    e.name = name;
    e.sig  = sig;
    e.mask = mask;
    e.exp  = exp;
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, e);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  // monitor: compares every expectation due at the current edge count
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].due <= edge_n) begin
      m_e = sb.pop_front();
      case (m_e.sig)
        SIG_IN:   m_act = {24'd0, bus.in_o};
        SIG_PEND: m_act = {24'd0, bus.irq_pend_o};
        SIG_IRQ:  m_act = {31'd0, bus.irq_o};
        SIG_FROM: m_act = {24'd0, bus.from_core_o};
        SIG_CFG:  m_act = {8'd0, bus.io_cell_cfg_o};
        default:  m_act = {28'd0, dut.cnt[4]};
      endcase
      checks++;
      if (m_e.due < edge_n) begin
        failures++;
        $display("FAIL %s: missed at edge %0d, now edge %0d", m_e.name, m_e.due, edge_n);
      end else if ((m_act & m_e.mask) !== (m_e.exp & m_e.mask)) begin
        failures++;
        $display("FAIL %s @edge %0d: got %h expected %h (mask %h)",
                 m_e.name, edge_n, m_act & m_e.mask, m_e.exp & m_e.mask, m_e.mask);
      end
    end
  end

  int t;

  initial begin
    checks   = 0;
    failures = 0;
    reset_in = 1'b1;
    bus.dir_i         = 8'hFF;
    bus.out_i         = 8'hFF;
    bus.pad_cfg_i     = 16'hFFFF;
    bus.filt_len_i    = 4'd0;
    bus.irq_rise_en_i = 8'h00;
    bus.irq_fall_en_i = 8'h00;
    bus.irq_clr_i     = 8'h00;
    bus.to_core_i     = 8'h00;

    // reset held with outputs/dirs/cfg requested high
    tick(3);
    t = edge_n;
    push(t, "rst_from_core", SIG_FROM, 32'hFF, 32'h00);
    push(t, "rst_cfg", SIG_CFG, 32'hFFFFFF, 32'h249249);
    push(t, "rst_in", SIG_IN, 32'hFF, 32'h00);
    push(t, "rst_pend", SIG_PEND, 32'hFF, 32'h00);
    push(t, "rst_irq", SIG_IRQ, 32'h1, 32'h0);
    reset_in = 1'b0;
    push(t + 1, "rel_from_core", SIG_FROM, 32'hFF, 32'hFF);
    push(t + 1, "rel_cfg", SIG_CFG, 32'hFFFFFF, 32'hDB6DB6);
    tick(1);
    bus.dir_i     = 8'h00;
    bus.out_i     = 8'h00;
    bus.pad_cfg_i = 16'h0000;
    push(t + 2, "idle_cfg", SIG_CFG, 32'hFFFFFF, 32'h249249);
    push(t + 2, "idle_from_core", SIG_FROM, 32'hFF, 32'h00);
    tick(1);

    // L=0 rising edge on pin 0
    bus.irq_rise_en_i = 8'h01;
    t = edge_n;
    bus.to_core_i[0] = 1'b1;
    push(t + 1, "p0_in_e0", SIG_IN, 32'h01, 32'h00);
    push(t + 2, "p0_in_e1", SIG_IN, 32'h01, 32'h00);
    push(t + 2, "p0_pend_e1", SIG_PEND, 32'h01, 32'h00);
    push(t + 2, "p0_irq_e1", SIG_IRQ, 32'h1, 32'h0);
    push(t + 3, "p0_in_e2", SIG_IN, 32'h01, 32'h01);
    push(t + 3, "p0_pend_e2", SIG_PEND, 32'h01, 32'h01);
    push(t + 3, "p0_irq_e2", SIG_IRQ, 32'h1, 32'h1);
    tick(3);
    bus.irq_clr_i = 8'h01;
    push(t + 4, "p0_clr", SIG_PEND, 32'h01, 32'h00);
    push(t + 4, "p0_irq_clr", SIG_IRQ, 32'h1, 32'h0);
    tick(1);
    bus.irq_clr_i = 8'h00;

    // L=3: 3-cycle pulse on pin 1 is rejected
    bus.filt_len_i    = 4'd3;
    bus.irq_rise_en_i = 8'h03;
    t = edge_n;
    bus.to_core_i[1] = 1'b1;
    for (int k = 1; k <= 8; k++) push(t + k, "p1_short_in", SIG_IN, 32'h02, 32'h00);
    push(t + 8, "p1_short_pend", SIG_PEND, 32'h02, 32'h00);
    tick(3);
    bus.to_core_i[1] = 1'b0;
    tick(5);

    // L=3: 4-cycle pulse on pin 1 is accepted at E5, released 4 cycles later
    t = edge_n;
    bus.to_core_i[1] = 1'b1;
    push(t + 5, "p1_long_in_e4", SIG_IN, 32'h02, 32'h00);
    push(t + 6, "p1_long_in_e5", SIG_IN, 32'h02, 32'h02);
    push(t + 6, "p1_long_pend", SIG_PEND, 32'h02, 32'h02);
    push(t + 9, "p1_hold_in", SIG_IN, 32'h02, 32'h02);
    push(t + 10, "p1_fall_in", SIG_IN, 32'h02, 32'h00);
    tick(4);
    bus.to_core_i[1] = 1'b0;
    tick(6);
    bus.irq_clr_i = 8'h02;
    push(edge_n + 1, "p1_clr", SIG_PEND, 32'h02, 32'h00);
    tick(1);
    bus.irq_clr_i = 8'h00;

    // L=0: pin 2 falling-only interrupt
    bus.filt_len_i    = 4'd0;
    bus.irq_fall_en_i = 8'h04;
    t = edge_n;
    bus.to_core_i[2] = 1'b1;
    push(t + 3, "p2_rise_in", SIG_IN, 32'h04, 32'h04);
    push(t + 3, "p2_rise_nopend", SIG_PEND, 32'h04, 32'h00);
    tick(3);
    t = edge_n;
    bus.to_core_i[2] = 1'b0;
    push(t + 2, "p2_fall_in_e1", SIG_IN, 32'h04, 32'h04);
    push(t + 2, "p2_fall_pend_e1", SIG_PEND, 32'h04, 32'h00);
    push(t + 3, "p2_fall_in_e2", SIG_IN, 32'h04, 32'h00);
    push(t + 3, "p2_fall_pend_e2", SIG_PEND, 32'h04, 32'h04);
    push(t + 3, "p2_irq", SIG_IRQ, 32'h1, 32'h1);
    tick(3);
    bus.irq_clr_i = 8'h04;
    push(edge_n + 1, "p2_clr", SIG_PEND, 32'h04, 32'h00);
    push(edge_n + 1, "p2_irq_clr", SIG_IRQ, 32'h1, 32'h0);
    tick(1);
    bus.irq_clr_i = 8'h00;

    // pin 3: set and clear on the same edge, set wins; disable keeps flag
    bus.irq_rise_en_i = 8'h0B;
    bus.irq_fall_en_i = 8'h0C;
    t = edge_n;
    bus.to_core_i[3] = 1'b1;
    push(t + 3, "p3_rise_pend", SIG_PEND, 32'h08, 32'h08);
    tick(3);
    bus.to_core_i[3] = 1'b0;
    tick(2);
    bus.irq_clr_i = 8'h08;
    push(t + 6, "p3_set_beats_clr", SIG_PEND, 32'h08, 32'h08);
    push(t + 6, "p3_fall_in", SIG_IN, 32'h08, 32'h00);
    tick(1);
    bus.irq_clr_i     = 8'h00;
    bus.irq_rise_en_i = 8'h03;
    bus.irq_fall_en_i = 8'h04;
    push(edge_n + 2, "p3_disable_keeps", SIG_PEND, 32'h08, 32'h08);
    tick(2);
    bus.irq_clr_i = 8'h08;
    push(edge_n + 1, "p3_clr", SIG_PEND, 32'h08, 32'h00);
    tick(1);
    bus.irq_clr_i = 8'h00;

    // pin 4: L=15 counting to 10, then L lowered to 2
    bus.filt_len_i = 4'd15;
    t = edge_n;
    bus.to_core_i[4] = 1'b1;
    push(t + 12, "p4_cnt10", SIG_CNT4, 32'hF, 32'd10);
    push(t + 12, "p4_in_pre", SIG_IN, 32'h10, 32'h00);
    tick(12);
    bus.filt_len_i = 4'd2;
    push(t + 13, "p4_in_lowered", SIG_IN, 32'h10, 32'h10);
    push(t + 13, "p4_cnt_zero", SIG_CNT4, 32'hF, 32'd0);
    tick(1);
    bus.to_core_i[4] = 1'b0;
    push(t + 17, "p4_fall_hold", SIG_IN, 32'h10, 32'h10);
    push(t + 17, "p4_cnt2", SIG_CNT4, 32'hF, 32'd2);
    push(t + 18, "p4_fall_in", SIG_IN, 32'h10, 32'h00);
    push(t + 18, "p4_no_pend", SIG_PEND, 32'h10, 32'h00);
    tick(5);

    for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
